// File: rtl/alu_pipe_if.sv
// Operand/result bus of alu_pipe: issue side (operands, op, valid/ready) and
// result side (result, flags, valid/ready). The controller is the master.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [3:0]         ALU_FUN;
    logic               IN_VALID;
    logic               IN_READY;
    logic [2*WIDTH-1:0] ALU_OUT;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic               CARRY_OUT;
    logic               ZERO_FLAG;
    logic               ERR_FLAG;
    logic [3:0]         CLASS_FLAG;

    modport master (
        output A, B, ALU_FUN, IN_VALID, OUT_READY,
        input  IN_READY, ALU_OUT, OUT_VALID, CARRY_OUT, ZERO_FLAG, ERR_FLAG, CLASS_FLAG
    );

    modport slave (
        input  A, B, ALU_FUN, IN_VALID, OUT_READY,
        output IN_READY, ALU_OUT, OUT_VALID, CARRY_OUT, ZERO_FLAG, ERR_FLAG, CLASS_FLAG
    );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle arithmetic/logic/compare/shift ops plus an
// optional restoring divider (one quotient bit per cycle), feeding a single
// registered result stage with valid/ready backpressure.
module alu_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter bit          DIV_EN = 1'b1
) (
    input logic       CLK,
    input logic       RST,
    alu_pipe_if.slave bus
);
    localparam int unsigned W2   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpMul  = 4'b0010;
    localparam logic [3:0] OpDiv  = 4'b0011;
    localparam logic [3:0] OpAnd  = 4'b0100;
    localparam logic [3:0] OpOr   = 4'b0101;
    localparam logic [3:0] OpNand = 4'b0110;
    localparam logic [3:0] OpNor  = 4'b0111;
    localparam logic [3:0] OpNop  = 4'b1000;
    localparam logic [3:0] OpEq   = 4'b1001;
    localparam logic [3:0] OpGt   = 4'b1010;
    localparam logic [3:0] OpLt   = 4'b1011;
    localparam logic [3:0] OpShrA = 4'b1100;
    localparam logic [3:0] OpShlA = 4'b1101;
    localparam logic [3:0] OpShrB = 4'b1110;
    localparam logic [3:0] OpShlB = 4'b1111;

    typedef enum logic {StIdle, StDivide} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Output register
    logic [W2-1:0] out_q;
    logic          carry_q, err_q, valid_q;
    logic [3:0]    class_q;

    logic          in_ready, accept, div_start, div_last, load;
    logic [WIDTH:0] sum;
    logic [W2-1:0] op_res, res_d;
    logic          op_carry, op_err, carry_d, err_d;
    logic [3:0]    class_d;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign in_ready  = (state_q == StIdle) && (!valid_q || bus.OUT_READY) && !RST;
    assign accept    = bus.IN_VALID && in_ready;
    assign div_start = accept && DIV_EN && (bus.ALU_FUN == OpDiv) && (bus.B != '0);
    assign div_last  = (state_q == StDivide) && (cnt_q == CntW'(1));
    assign load      = (accept && !div_start) || div_last;
    assign sum       = {1'b0, bus.A} + {1'b0, bus.B};

    // Single-cycle result for the op currently presented at the input
    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_err   = 1'b0;
        unique case (bus.ALU_FUN)
            OpAdd: begin
                op_res[WIDTH:0] = sum;
                op_carry        = sum[WIDTH];
            end
            OpSub: begin
                op_res[WIDTH-1:0] = bus.A - bus.B;
                op_carry          = bus.A < bus.B;
            end
            OpMul: op_res = W2'(bus.A) * W2'(bus.B);
            // Only reaches the output register for B==0 or without a divider;
            // a real division goes through the sequential path instead.
            OpDiv: begin
                op_err = 1'b1;
                if (DIV_EN) op_res = {bus.A, {WIDTH{1'b1}}};
            end
            OpAnd:  op_res[WIDTH-1:0] = bus.A & bus.B;
            OpOr:   op_res[WIDTH-1:0] = bus.A | bus.B;
            OpNand: op_res[WIDTH-1:0] = ~(bus.A & bus.B);
            OpNor:  op_res[WIDTH-1:0] = ~(bus.A | bus.B);
            OpNop:  op_res = '0;
            OpEq:   op_res[0] = bus.A == bus.B;
            OpGt:   op_res[0] = bus.A > bus.B;
            OpLt:   op_res[0] = bus.A < bus.B;
            OpShrA: begin
                op_res[WIDTH-1:0] = {1'b0, bus.A[WIDTH-1:1]};
                op_carry          = bus.A[0];
            end
            OpShlA: begin
                op_res[WIDTH-1:0] = {bus.A[WIDTH-2:0], 1'b0};
                op_carry          = bus.A[WIDTH-1];
            end
            OpShrB: begin
                op_res[WIDTH-1:0] = {1'b0, bus.B[WIDTH-1:1]};
                op_carry          = bus.B[0];
            end
            OpShlB: begin
                op_res[WIDTH-1:0] = {bus.B[WIDTH-2:0], 1'b0};
                op_carry          = bus.B[WIDTH-1];
            end
        endcase
    end

    // Select what the output register loads: divider result or single-cycle op
    always_comb begin
        if (div_last) begin
            res_d   = {step_rem, step_quo};
            carry_d = 1'b0;
            err_d   = 1'b0;
            class_d = 4'b0001;
        end else begin
            res_d   = op_res;
            carry_d = op_carry;
            err_d   = op_err;
            class_d = 4'b0001 << bus.ALU_FUN[3:2];
        end
    end

    // FSM next state and divide iteration counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (div_start) begin
                    state_d = StDivide;
                    cnt_d   = CntW'(WIDTH);
                end
            end
            StDivide: begin
                cnt_d = cnt_q - CntW'(1);
                if (div_last) state_d = StIdle;
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output register: load wins over drain, so drain+load keeps valid high
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            class_q <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            out_q   <= res_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            class_q <= class_d;
            valid_q <= 1'b1;
        end else if (bus.OUT_READY) begin
            valid_q <= 1'b0;
        end
    end

    if (DIV_EN) begin : gen_div
        logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
        logic [WIDTH:0]   shifted, diff;

        // Shift next dividend bit into the partial remainder; restore on borrow
        assign shifted  = {rem_q, quo_q[WIDTH-1]};
        assign diff     = shifted - {1'b0, dvs_q};
        assign step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        assign step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

        // Divider datapath: operands captured on accept, one step per DIVIDE cycle
        always_ff @(posedge CLK) begin
            if (RST) begin
                rem_q <= '0;
                quo_q <= '0;
                dvs_q <= '0;
            end else if (div_start) begin
                rem_q <= '0;
                quo_q <= bus.A;
                dvs_q <= bus.B;
            end else if (state_q == StDivide) begin
                rem_q <= step_rem;
                quo_q <= step_quo;
            end
        end
    end else begin : gen_no_div
        assign step_rem = '0;
        assign step_quo = '0;
    end

    assign bus.IN_READY   = in_ready;
    assign bus.ALU_OUT    = out_q;
    assign bus.OUT_VALID  = valid_q;
    assign bus.CARRY_OUT  = carry_q;
    assign bus.ERR_FLAG   = err_q;
    assign bus.ZERO_FLAG  = valid_q && (out_q == '0);
    assign bus.CLASS_FLAG = valid_q ? class_q : 4'b0000;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push expected results into a
// queue, a negedge monitor pops and compares on every output handshake.
module tb_alu_pipe;
    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpMul  = 4'b0010;
    localparam logic [3:0] OpDiv  = 4'b0011;
    localparam logic [3:0] OpAnd  = 4'b0100;
    localparam logic [3:0] OpOr   = 4'b0101;
    localparam logic [3:0] OpNand = 4'b0110;
    localparam logic [3:0] OpNor  = 4'b0111;
    localparam logic [3:0] OpNop  = 4'b1000;
    localparam logic [3:0] OpEq   = 4'b1001;
    localparam logic [3:0] OpGt   = 4'b1010;
    localparam logic [3:0] OpLt   = 4'b1011;
    localparam logic [3:0] OpShrA = 4'b1100;
    localparam logic [3:0] OpShlA = 4'b1101;
    localparam logic [3:0] OpShrB = 4'b1110;
    localparam logic [3:0] OpShlB = 4'b1111;

    typedef struct {
        logic [31:0] out;
        logic        carry;
        logic        zero;
        logic        err;
        logic [3:0]  cls;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    alu_pipe_if #(.WIDTH(16)) bus ();
    alu_pipe_if #(.WIDTH(16)) bus2 ();

    alu_pipe #(.WIDTH(16), .DIV_EN(1'b1)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    alu_pipe #(.WIDTH(16), .DIV_EN(1'b0)) dut_nodiv (
        .CLK (clk),
        .RST (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] eo, input logic ec, input logic ee,
                         input logic [3:0] cls, input bit push);
        int   n;
        exp_t e;
        n = 0;
        bus.ALU_FUN  = fun;
        bus.A        = a;
        bus.B        = b;
        bus.IN_VALID = 1'b1;
        @(negedge clk);
        while (!bus.IN_READY && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.IN_READY) begin
            checks++;
            failures++;
            $display("FAIL issue_accept op=%b got_in_ready=0 expected=1", fun);
            bus.IN_VALID = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            if (push) begin
                e.out   = eo;
                e.carry = ec;
                e.zero  = (eo == 32'h0);
                e.err   = ee;
                e.cls   = cls;
                exp_q.push_back(e);
            end
            #1;
            bus.IN_VALID = 1'b0;
        end
    endtask

    // Monitor: one pop per output handshake
    always @(negedge clk) begin
        if (bus.OUT_VALID && bus.OUT_READY) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result got=%h expected=none", bus.ALU_OUT);
            end else begin
                mon_e = exp_q.pop_front();
                pops++;
                if (bus.ALU_OUT !== mon_e.out || bus.CARRY_OUT !== mon_e.carry ||
                    bus.ZERO_FLAG !== mon_e.zero || bus.ERR_FLAG !== mon_e.err ||
                    bus.CLASS_FLAG !== mon_e.cls) begin
                    failures++;
                    $display("FAIL result got=%h/c%b/z%b/e%b/cls%b expected=%h/c%b/z%b/e%b/cls%b",
                             bus.ALU_OUT, bus.CARRY_OUT, bus.ZERO_FLAG, bus.ERR_FLAG,
                             bus.CLASS_FLAG, mon_e.out, mon_e.carry, mon_e.zero, mon_e.err,
                             mon_e.cls);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int     bad;
        int     p0;
        longint t0;
        rst = 1'b1;
        bus.IN_VALID = 1'b0; bus.A = '0; bus.B = '0; bus.ALU_FUN = '0; bus.OUT_READY = 1'b1;
        bus2.IN_VALID = 1'b0; bus2.A = '0; bus2.B = '0; bus2.ALU_FUN = '0; bus2.OUT_READY = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.IN_READY, 0);
        check("rst_out_valid", bus.OUT_VALID, 0);
        check("rst_alu_out", bus.ALU_OUT, 0);
        check("rst_flags", {bus.CARRY_OUT, bus.ZERO_FLAG, bus.ERR_FLAG, bus.CLASS_FLAG}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.IN_READY, 1);
        @(posedge clk); #1;

        // Arithmetic, single-cycle latency
        issue(OpAdd, 16'hFFFF, 16'h0001, 32'h0001_0000, 1, 0, 4'b0001, 1);
        check("add_latency", bus.OUT_VALID, 1);
        issue(OpSub, 16'd3, 16'd5, 32'h0000_FFFE, 1, 0, 4'b0001, 1);

        // Division, operands disturbed mid-way
        issue(OpDiv, 16'd100, 16'd7, 32'h0002_000E, 0, 0, 4'b0001, 1);
        bad = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (bus.IN_READY || bus.OUT_VALID) bad++;
            if (j == 5) begin
                bus.A = 16'hDEAD;
                bus.B = 16'h0003;
            end
        end
        check("div_busy_cycles", bad, 0);
        @(negedge clk);
        check("div_latency_valid", bus.OUT_VALID, 1);
        check("div_ready_back", bus.IN_READY, 1);
        @(posedge clk); #1;

        // Divide by zero
        issue(OpDiv, 16'h1234, 16'h0000, 32'h1234_FFFF, 0, 1, 4'b0001, 1);
        check("div0_latency", bus.OUT_VALID, 1);
        @(posedge clk); #1;

        // Backpressure hold, then drain+load on the same edge
        bus.OUT_READY = 1'b0;
        issue(OpMul, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 0, 4'b0001, 1);
        bad = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (!bus.OUT_VALID || bus.IN_READY || bus.ALU_OUT !== 32'hFFFE_0001 ||
                bus.CARRY_OUT || bus.ERR_FLAG || bus.CLASS_FLAG !== 4'b0001) bad++;
        end
        check("bp_hold", bad, 0);
        @(posedge clk); #1;
        bus.OUT_READY = 1'b1;
        issue(OpAnd, 16'hF0F0, 16'h0FF0, 32'h0000_00F0, 0, 0, 4'b0010, 1);
        check("bp_load_valid", bus.OUT_VALID, 1);
        check("bp_load_out", bus.ALU_OUT, 32'h0000_00F0);

        // Reset in the middle of a division
        issue(OpDiv, 16'd1000, 16'd3, 32'h0, 0, 0, 4'b0001, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_div_in_ready", bus.IN_READY, 0);
        @(posedge clk); #1;
        check("rst_div_valid", bus.OUT_VALID, 0);
        check("rst_div_out", bus.ALU_OUT, 0);
        check("rst_div_flags", {bus.CARRY_OUT, bus.ZERO_FLAG, bus.ERR_FLAG, bus.CLASS_FLAG}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_div_ready_back", bus.IN_READY, 1);
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (bus.OUT_VALID) bad++;
        end
        check("rst_div_no_stale", bad, 0);
        @(posedge clk); #1;

        issue(OpGt, 16'd5, 16'd3, 32'h1, 0, 0, 4'b0100, 1);
        check("gt_class", bus.CLASS_FLAG, 4'b0100);
        issue(OpNop, 16'h1234, 16'h0001, 32'h0, 0, 0, 4'b0100, 1);
        check("nop_zero", bus.ZERO_FLAG, 1);

        // Back-to-back burst, one accept per cycle
        p0 = pops;
        t0 = $time;
        issue(OpShlA, 16'h8001, 16'hFFFF, 32'h0000_0002, 1, 0, 4'b1000, 1);
        issue(OpShrB, 16'hFFFF, 16'h0003, 32'h0000_0001, 1, 0, 4'b1000, 1);
        issue(OpShrA, 16'h0004, 16'h0001, 32'h0000_0002, 0, 0, 4'b1000, 1);
        issue(OpShlB, 16'h0001, 16'h8000, 32'h0000_0000, 1, 0, 4'b1000, 1);
        issue(OpOr,   16'h1200, 16'h0034, 32'h0000_1234, 0, 0, 4'b0010, 1);
        issue(OpNand, 16'hFFFF, 16'h00FF, 32'h0000_FF00, 0, 0, 4'b0010, 1);
        issue(OpNor,  16'h0000, 16'h0000, 32'h0000_FFFF, 0, 0, 4'b0010, 1);
        issue(OpEq,   16'd7, 16'd7, 32'h1, 0, 0, 4'b0100, 1);
        issue(OpLt,   16'd3, 16'd5, 32'h1, 0, 0, 4'b0100, 1);
        issue(OpAdd,  16'h0000, 16'h0000, 32'h0, 0, 0, 4'b0001, 1);
        check("burst_time", 32'($time - t0), 32'd100);
        @(negedge clk);
        check("burst_results", pops - p0, 10);
        @(posedge clk); #1;

        // Instance without a divider
        bus2.ALU_FUN = OpDiv; bus2.A = 16'h1234; bus2.B = 16'h0005; bus2.IN_VALID = 1'b1;
        @(posedge clk); #1;
        bus2.IN_VALID = 1'b0;
        check("nodiv_valid", bus2.OUT_VALID, 1);
        check("nodiv_out", bus2.ALU_OUT, 0);
        check("nodiv_err", bus2.ERR_FLAG, 1);
        check("nodiv_zero_class", {bus2.ZERO_FLAG, bus2.CLASS_FLAG}, 5'b1_0001);
        bus2.B = 16'h0000; bus2.IN_VALID = 1'b1;
        @(posedge clk); #1;
        bus2.IN_VALID = 1'b0;
        check("nodiv_b0_out", bus2.ALU_OUT, 0);
        check("nodiv_b0_err", bus2.ERR_FLAG, 1);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 16-bit four-unit ALU. It keeps the same 4-bit `ALU_FUN` map, with the upper two bits selecting the class (arithmetic, logic, compare, shift). It drives a single registered result bus with valid/ready flow control on input and output. It adds unsigned multi-cycle division, carry/zero/error flags and output backpressure. It sits between an operand-issuing controller and a result consumer in the datapath.

## Interface
- `WIDTH`, 16, operand width in bits; ≥ 4.
- `DIV_EN`, 1, 1 = sequential divider present; 0 = divide code returns 0 with `ERR_FLAG`=1, no divider logic.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `A`  in  WIDTH  operand A, unsigned.
- `B`  in  WIDTH  operand B, unsigned.
- `ALU_FUN`  in  4  operation code.
- `IN_VALID`  in  1  operands/op valid.
- `IN_READY`  out  1  block can accept this cycle.
- `ALU_OUT`  out  2*WIDTH  result.
- `OUT_VALID`  out  1  result valid.
- `OUT_READY`  in  1  consumer takes result.
- `CARRY_OUT`  out  1  carry/borrow/shifted-out bit.
- `ZERO_FLAG`  out  1  `ALU_OUT` == 0.
- `ERR_FLAG`  out  1  divide by zero, or divide with `DIV_EN`=0.
- `CLASS_FLAG`  out  4  one-hot class of the held result: [0] arith, [1] logic, [2] cmp, [3] shift.

## Operation
- Opcodes; every result is zero-extended to 2*WIDTH unless stated otherwise.
  - 0000 ADD: `ALU_OUT` = A+B on WIDTH+1 bits; `CARRY_OUT` = bit WIDTH.
  - 0001 SUB: `ALU_OUT` = (A−B) mod 2^WIDTH; `CARRY_OUT` = borrow (A<B).
  - 0010 MUL: full 2*WIDTH product.
  - 0011 DIV: {remainder, quotient}; remainder in the upper WIDTH bits.
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR: bitwise on WIDTH bits.
  - 1000 NOP: result 0. 1001 EQ, 1010 GT, 1011 LT: result 1 if true, else 0.
  - 1100 A>>1, 1101 A<<1, 1110 B>>1, 1111 B<<1: WIDTH-bit result; `CARRY_OUT` = bit shifted out.
- `CARRY_OUT` is 0 for all ops not listed with a carry.
- `ZERO_FLAG` is evaluated over the full 2*WIDTH result.
- `ERR_FLAG` is 0 for all ops except the DIV error cases.
- State machine:
  - IDLE: accepts a transaction when `IN_VALID`·`IN_READY`.
    - Non-DIV op, DIV with B=0, or DIV with `DIV_EN`=0: result written to the output register; stay in IDLE.
    - DIV with B≠0 and `DIV_EN`=1: capture A and B, load counter = WIDTH, go to DIVIDE.
  - DIVIDE: restoring division, one quotient bit per cycle; counter decrements each cycle. On the last iteration, write the result to the output register and return to IDLE.
- `IN_READY` = (state==IDLE) · (!`OUT_VALID` + `OUT_READY`) · !`RST`.
  - Consequence: the output register is always empty when DIVIDE completes, so there is no overflow case.
- Output register:
  - Loads on accept (single-cycle ops) or on DIVIDE completion.
  - Clears `OUT_VALID` on `OUT_READY` when there is no simultaneous load.
  - Simultaneous drain and load: the new result replaces the old one and `OUT_VALID` stays 1.
- Hold rule: while `OUT_VALID`·!`OUT_READY`, the following stay bit-stable: `ALU_OUT`, `CARRY_OUT`, `ZERO_FLAG`, `ERR_FLAG`, `CLASS_FLAG`.
- DIV by zero: quotient = all ones, remainder = A, `ERR_FLAG`=1, single-cycle path.
- `CLASS_FLAG` = 0 whenever `OUT_VALID`=0.
- Inputs are ignored whenever `IN_VALID`·`IN_READY` is not true. Operands are sampled only on the accept edge, so A and B may change during DIVIDE.

## Timing
- Reset (sampled on a `CLK` edge with `RST`=1):
  - State → IDLE, divider counter cleared.
  - All outputs 0, including `IN_READY` while `RST`=1 and `ZERO_FLAG`. `ZERO_FLAG` is gated by `OUT_VALID`.
  - Reset during DIVIDE aborts the division; no result is produced.
  - `IN_READY`=1 in the first cycle after `RST` falls.
- Single-cycle ops: accepted at edge k, `OUT_VALID`=1 from edge k.
  - Throughput is 1 op/cycle with `OUT_READY` held high.
- DIV (B≠0): accepted at edge k; result and `OUT_VALID` valid from edge k+WIDTH.
  - `IN_READY`=0 from edge k through edge k+WIDTH−1.
  - `IN_READY` returns to 1 in the cycle `OUT_VALID` rises, subject to `OUT_READY`.
- Multiply is combinational into the output register (1 cycle); no pipeline bubble.

## Test plan
- WIDTH=16. ADD A=0xFFFF, B=0x0001 → `ALU_OUT`=0x00010000, `CARRY_OUT`=1, `ZERO_FLAG`=0, `CLASS_FLAG`=0001, `OUT_VALID` one edge after accept. SUB A=3, B=5 → 0x0000FFFE, `CARRY_OUT`=1.
- DIV A=100, B=7 → `ALU_OUT`=0x0002000E, `OUT_VALID` exactly 16 edges after accept, `IN_READY`=0 for those 16 cycles. Change A and B mid-division; the result must be unaffected.
- DIV A=0x1234, B=0 → `ALU_OUT`=0x1234FFFF, `ERR_FLAG`=1, 1-cycle latency. With `DIV_EN`=0, any DIV → 0, `ERR_FLAG`=1.
- Backpressure: `OUT_READY`=0, issue MUL 0xFFFF×0xFFFF → 0xFFFE0001 held stable and `IN_READY`=0 for 5 cycles. Raise `OUT_READY` with AND 0xF0F0&0x0FF0 presented → old result drains and 0x000000F0 loads on the same edge.
- Reset at cycle 5 of a DIV → all outputs 0, no stale result. The next GT 5>3 → `ALU_OUT`=1, `CLASS_FLAG`=0100. NOP → `ZERO_FLAG`=1.
- Shifts: A<<1 with A=0x8001 → 0x00000002, `CARRY_OUT`=1. B>>1 with B=0x0003 → 0x00000001, `CARRY_OUT`=1. Back-to-back issue: one result per cycle.
